// File: rtl/fitness_pkg.sv
// -----------------------------------------------------------------------------
// fitness_pkg
// Shared definitions for the workout sequencer slice.
//   ST_IDLE..ST_DONE : 3-bit encodings of the workout_state output
//   state_t          : FSM state type, built on those encodings
//   tick_cycles()    : clock cycles that make up one "second", either the real
//                      clock rate or a short simulation period
// -----------------------------------------------------------------------------
package fitness_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WORK  = 3'd1;
  localparam logic [2:0] ST_REST  = 3'd2;
  localparam logic [2:0] ST_PAUSE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    WORK  = ST_WORK,
    REST  = ST_REST,
    PAUSE = ST_PAUSE,
    DONE  = ST_DONE
  } state_t;

  // A non-zero speedup selects the short simulated second so that whole
  // workouts fit in a few hundred cycles.
  function automatic int unsigned tick_cycles(input int unsigned sim_speedup,
                                              input int unsigned sim_tick_cycles,
                                              input int unsigned clk_hz);
    return (sim_speedup != 0) ? sim_tick_cycles : clk_hz;
  endfunction

endpackage

// File: rtl/second_tick_gen.sv
// -----------------------------------------------------------------------------
// second_tick_gen
// Prescaler that produces a one-cycle sec_tick every CYCLES enabled cycles.
//   clk_40MHz : system clock
//   rst       : synchronous active-high reset, clears the count
//   en        : count only while high; the count holds when low
//   clr       : restart the second from zero (takes priority over en)
//   sec_tick  : high for the enabled cycle in which the count wraps
// -----------------------------------------------------------------------------
module second_tick_gen #(
  parameter int unsigned CYCLES = 4,
  parameter int          CNT_W  = 2
) (
  input  logic clk_40MHz,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic sec_tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // The tick is decoded from the count so the sequencer sees it in the same
  // cycle the wrap is taken, and can register its update on that edge.
  assign sec_tick = en && (cnt == LAST);

  // Free-running 0..CYCLES-1 counter; clr wins so a new phase always starts
  // with a full second, and a low enable freezes a partially elapsed second.
  always_ff @(posedge clk_40MHz) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/workout_sequencer.sv
// -----------------------------------------------------------------------------
// workout_sequencer
// Steps through num_ex exercises, each a WORK countdown optionally followed by
// a REST countdown, then parks in DONE. Supports pause/resume and skip, and
// emits a retriggerable buzzer pulse on every WORK/REST/DONE entry.
//   clk_40MHz            : system clock
//   rst                  : synchronous active-high reset
//   start_p              : start pulse, honoured in IDLE/DONE only
//   skip_p               : end the current WORK/REST phase early
//   pause_p              : toggle between a running phase and PAUSE
//   num_ex/work_sec/rest_sec : workout configuration, latched at start
//   workout_state        : 0 IDLE, 1 WORK, 2 REST, 3 PAUSE, 4 DONE
//   current_exercise_num : 1-based exercise number, 0 before the first start
//   countdown_seconds    : seconds left in the current phase
//   buzzer               : BEEP_CYCLES-long pulse after each phase entry
//   done                 : high while in DONE
// -----------------------------------------------------------------------------
module workout_sequencer
  import fitness_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 40000000,
  parameter int unsigned SIM_SPEEDUP     = 0,
  parameter int unsigned SIM_TICK_CYCLES = 4,
  parameter int          EX_W            = 9,
  parameter int          SEC_W           = 8,
  parameter int unsigned BEEP_CYCLES     = CLK_HZ / 10
) (
  input  logic             clk_40MHz,
  input  logic             rst,
  input  logic             start_p,
  input  logic             skip_p,
  input  logic             pause_p,
  input  logic [EX_W-1:0]  num_ex,
  input  logic [SEC_W-1:0] work_sec,
  input  logic [SEC_W-1:0] rest_sec,
  output logic [2:0]       workout_state,
  output logic [EX_W-1:0]  current_exercise_num,
  output logic [SEC_W-1:0] countdown_seconds,
  output logic             buzzer,
  output logic             done
);

  localparam int unsigned TICK   = tick_cycles(SIM_SPEEDUP, SIM_TICK_CYCLES, CLK_HZ);
  localparam int          TICK_W = (TICK > 1) ? $clog2(TICK) : 1;
  localparam int          BEEP_W = $clog2(BEEP_CYCLES + 1);
  localparam logic [BEEP_W-1:0] BEEP_LOAD = BEEP_W'(BEEP_CYCLES - 1);

  state_t             state;
  state_t             saved_phase;
  logic [EX_W-1:0]    exercise;
  logic [SEC_W-1:0]   countdown;
  logic [EX_W-1:0]    n_lat;
  logic [SEC_W-1:0]   work_lat;
  logic [SEC_W-1:0]   rest_lat;
  logic [BEEP_W-1:0]  buzz_cnt;

  logic running;
  logic start_ok;
  logic phase_end;
  logic tick_en;
  logic tick_clr;
  logic sec_tick;

  // Event decode shared by the prescaler and the FSM. A pause pulse masks the
  // prescaler in the cycle it arrives, so a tick landing on that cycle is held
  // back rather than lost, and skip/tick are ignored beneath a pause.
  always_comb begin
    running   = (state == WORK) || (state == REST);
    start_ok  = ((state == IDLE) || (state == DONE)) && start_p &&
                (num_ex != '0) && (work_sec != '0);
    phase_end = running && !pause_p &&
                (skip_p || (sec_tick && (countdown == SEC_W'(1))));
    tick_en   = running && !pause_p;
    tick_clr  = start_ok || phase_end;
  end

  second_tick_gen #(
    .CYCLES (TICK),
    .CNT_W  (TICK_W)
  ) u_tick (
    .clk_40MHz (clk_40MHz),
    .rst       (rst),
    .en        (tick_en),
    .clr       (tick_clr),
    .sec_tick  (sec_tick)
  );

  // Main sequencer: state, counters, latched configuration and buzzer timer.
  // The buzzer timer runs down every cycle regardless of state; any phase
  // entry further down reloads it, which restarts a pulse already in flight.
  always_ff @(posedge clk_40MHz) begin
    if (rst) begin
      state       <= IDLE;
      saved_phase <= IDLE;
      exercise    <= '0;
      countdown   <= '0;
      n_lat       <= '0;
      work_lat    <= '0;
      rest_lat    <= '0;
      buzz_cnt    <= '0;
      buzzer      <= 1'b0;
      done        <= 1'b0;
    end else begin
      if (buzz_cnt != '0) buzz_cnt <= buzz_cnt - BEEP_W'(1);
      else                buzzer   <= 1'b0;

      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            n_lat     <= num_ex;
            work_lat  <= work_sec;
            rest_lat  <= rest_sec;
            state     <= WORK;
            exercise  <= EX_W'(1);
            countdown <= work_sec;
            done      <= 1'b0;
            buzzer    <= 1'b1;
            buzz_cnt  <= BEEP_LOAD;
          end
        end

        WORK: begin
          if (pause_p) begin
            saved_phase <= WORK;
            state       <= PAUSE;
          end else if (phase_end) begin
            buzzer   <= 1'b1;
            buzz_cnt <= BEEP_LOAD;
            if (exercise == n_lat) begin
              state     <= DONE;
              countdown <= '0;
              done      <= 1'b1;
            end else if (rest_lat == '0) begin
              exercise  <= exercise + EX_W'(1);
              countdown <= work_lat;
            end else begin
              state     <= REST;
              countdown <= rest_lat;
            end
          end else if (sec_tick) begin
            countdown <= countdown - SEC_W'(1);
          end
        end

        REST: begin
          if (pause_p) begin
            saved_phase <= REST;
            state       <= PAUSE;
          end else if (phase_end) begin
            state     <= WORK;
            exercise  <= exercise + EX_W'(1);
            countdown <= work_lat;
            buzzer    <= 1'b1;
            buzz_cnt  <= BEEP_LOAD;
          end else if (sec_tick) begin
            countdown <= countdown - SEC_W'(1);
          end
        end

        PAUSE: begin
          if (pause_p) state <= saved_phase;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign workout_state        = state;
  assign current_exercise_num = exercise;
  assign countdown_seconds    = countdown;

endmodule

// File: tb/tb_workout_sequencer.sv
// -----------------------------------------------------------------------------
// tb_workout_sequencer
// Directed bench for workout_sequencer in simulation-speed mode (4-cycle
// second, 2-cycle buzzer). Each stimulus step advances a reference model and
// queues the outputs it predicts; the queue is drained and compared after the
// clock edge. Directed constant checks pin down the key timing points.
// -----------------------------------------------------------------------------
module tb_workout_sequencer;

  localparam int TICK = 4;
  localparam int BEEP = 2;

  logic       clk_40MHz = 1'b0;
  logic       rst       = 1'b0;
  logic       start_p   = 1'b0;
  logic       skip_p    = 1'b0;
  logic       pause_p   = 1'b0;
  logic [8:0] num_ex    = '0;
  logic [7:0] work_sec  = '0;
  logic [7:0] rest_sec  = '0;
  logic [2:0] workout_state;
  logic [8:0] current_exercise_num;
  logic [7:0] countdown_seconds;
  logic       buzzer;
  logic       done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic [2:0] st;
    logic [8:0] ex;
    logic [7:0] cd;
    logic       bz;
    logic       dn;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  logic [2:0] ms;
  logic [2:0] msaved;
  logic [8:0] mex;
  logic [7:0] mcd;
  logic [8:0] mn;
  logic [7:0] mw;
  logic [7:0] mr;
  logic       mdone;
  int         mpre;
  int         mbeep;

  workout_sequencer #(
    .CLK_HZ          (40000000),
    .SIM_SPEEDUP     (1),
    .SIM_TICK_CYCLES (4),
    .EX_W            (9),
    .SEC_W           (8),
    .BEEP_CYCLES     (2)
  ) dut (
    .clk_40MHz            (clk_40MHz),
    .rst                  (rst),
    .start_p              (start_p),
    .skip_p               (skip_p),
    .pause_p              (pause_p),
    .num_ex               (num_ex),
    .work_sec             (work_sec),
    .rest_sec             (rest_sec),
    .workout_state        (workout_state),
    .current_exercise_num (current_exercise_num),
    .countdown_seconds    (countdown_seconds),
    .buzzer               (buzzer),
    .done                 (done)
  );

  // 10 ns clock
  always #5 clk_40MHz = ~clk_40MHz;

  // Predict the outputs one edge ahead from the inputs of this cycle.
  task automatic modelStep(input logic s, input logic k, input logic p, input logic r);
    logic run;
    logic tick;
    logic entered;
    if (r) begin
      ms = 3'd0; msaved = 3'd0; mex = '0; mcd = '0; mn = '0; mw = '0; mr = '0;
      mdone = 1'b0; mpre = 0; mbeep = 0;
      return;
    end
    run     = (ms == 3'd1) || (ms == 3'd2);
    tick    = run && !p && (mpre == TICK - 1);
    entered = 1'b0;
    if (mbeep > 0) mbeep = mbeep - 1;
    if (run && !p) mpre = (mpre + 1) % TICK;
    case (ms)
      3'd0, 3'd4: begin
        if (s && num_ex != 0 && work_sec != 0) begin
          mn = num_ex; mw = work_sec; mr = rest_sec;
          ms = 3'd1; mex = 9'd1; mcd = work_sec; mdone = 1'b0; entered = 1'b1;
        end
      end
      3'd1, 3'd2: begin
        if (p) begin
          msaved = ms;
          ms = 3'd3;
        end else if (k || (tick && mcd == 8'd1)) begin
          entered = 1'b1;
          if (ms == 3'd2) begin
            ms = 3'd1; mex = mex + 9'd1; mcd = mw;
          end else if (mex == mn) begin
            ms = 3'd4; mcd = 8'd0; mdone = 1'b1;
          end else if (mr == 8'd0) begin
            mex = mex + 9'd1; mcd = mw;
          end else begin
            ms = 3'd2; mcd = mr;
          end
        end else if (tick) begin
          mcd = mcd - 8'd1;
        end
      end
      3'd3: if (p) ms = msaved;
      default: ms = 3'd0;
    endcase
    if (entered) begin
      mpre  = 0;
      mbeep = BEEP;
    end
  endtask

  // Pop the oldest prediction and compare every output against it.
  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    checks++;
    assert (workout_state === e.st) else begin
      failures++;
      $error("[TB] FAIL %s.state observed=%0d expected=%0d", e.tag, workout_state, e.st);
    end
    checks++;
    assert (current_exercise_num === e.ex) else begin
      failures++;
      $error("[TB] FAIL %s.exercise observed=%0d expected=%0d", e.tag, current_exercise_num, e.ex);
    end
    checks++;
    assert (countdown_seconds === e.cd) else begin
      failures++;
      $error("[TB] FAIL %s.countdown observed=%0d expected=%0d", e.tag, countdown_seconds, e.cd);
    end
    checks++;
    assert (buzzer === e.bz) else begin
      failures++;
      $error("[TB] FAIL %s.buzzer observed=%0b expected=%0b", e.tag, buzzer, e.bz);
    end
    checks++;
    assert (done === e.dn) else begin
      failures++;
      $error("[TB] FAIL %s.done observed=%0b expected=%0b", e.tag, done, e.dn);
    end
  endtask

  // Directed comparison against a hand-derived constant.
  task automatic checkValue(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, queue the prediction, then compare after the edge.
  task automatic applyStimulus(input string tag, input logic s, input logic k,
                               input logic p, input logic r);
    exp_t e;
    start_p = s;
    skip_p  = k;
    pause_p = p;
    rst     = r;
    modelStep(s, k, p, r);
    e.tag = tag; e.st = ms; e.ex = mex; e.cd = mcd; e.bz = (mbeep > 0); e.dn = mdone;
    sb.push_back(e);
    @(posedge clk_40MHz);
    #1;
    start_p = 1'b0;
    skip_p  = 1'b0;
    pause_p = 1'b0;
    rst     = 1'b0;
    checkOutput();
  endtask

  task automatic runIdle(input string tag, input int n);
    for (int i = 0; i < n; i++) applyStimulus(tag, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int w1, rs, w2, bz, maxex, restSeen;

    ms = '0; msaved = '0; mex = '0; mcd = '0; mn = '0; mw = '0; mr = '0;
    mdone = 1'b0; mpre = 0; mbeep = 0;

    #2;
    applyStimulus("por", 1'b0, 1'b0, 1'b0, 1'b1);
    checkValue("por_state", int'(workout_state), 0);

    // Reset in the middle of a workout, while the buzzer is still high
    $display("[TB] reset mid-WORK");
    num_ex = 9'd3; work_sec = 8'd3; rest_sec = 8'd1;
    applyStimulus("t1_start", 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus("t1_run", 1'b0, 1'b0, 1'b0, 1'b0);
    checkValue("t1_buzz_before_rst", int'(buzzer), 1);
    applyStimulus("t1_rst", 1'b0, 1'b0, 1'b0, 1'b1);
    checkValue("t1_state", int'(workout_state), 0);
    checkValue("t1_exercise", int'(current_exercise_num), 0);
    checkValue("t1_countdown", int'(countdown_seconds), 0);
    checkValue("t1_buzzer", int'(buzzer), 0);
    checkValue("t1_done", int'(done), 0);

    // Invalid configurations are ignored
    $display("[TB] invalid start");
    num_ex = 9'd0; work_sec = 8'd3;
    applyStimulus("t2_zero_ex", 1'b1, 1'b0, 1'b0, 1'b0);
    checkValue("t2_zero_ex_state", int'(workout_state), 0);
    num_ex = 9'd2; work_sec = 8'd0;
    applyStimulus("t2_zero_work", 1'b1, 1'b0, 1'b0, 1'b0);
    checkValue("t2_zero_work_state", int'(workout_state), 0);
    applyStimulus("t2_skip_idle", 1'b0, 1'b1, 1'b1, 1'b0);

    // Full two-exercise workout with rest
    $display("[TB] full workout with rest");
    num_ex = 9'd2; work_sec = 8'd3; rest_sec = 8'd2;
    w1 = 0; rs = 0; w2 = 0; bz = 0;
    for (int i = 0; i < 41; i++) begin
      applyStimulus("t3", (i == 0), 1'b0, 1'b0, 1'b0);
      if (workout_state == 3'd1 && current_exercise_num == 9'd1) w1++;
      if (workout_state == 3'd2) rs++;
      if (workout_state == 3'd1 && current_exercise_num == 9'd2) w2++;
      if (buzzer) bz++;
    end
    checkValue("t3_work1_cycles", w1, 12);
    checkValue("t3_rest_cycles", rs, 8);
    checkValue("t3_work2_cycles", w2, 12);
    checkValue("t3_buzz_cycles", bz, 8);
    checkValue("t3_final_state", int'(workout_state), 4);
    checkValue("t3_final_exercise", int'(current_exercise_num), 2);
    checkValue("t3_final_done", int'(done), 1);

    // Restart from DONE without rest phases
    $display("[TB] workout without rest");
    num_ex = 9'd3; work_sec = 8'd2; rest_sec = 8'd0;
    restSeen = 0; maxex = 0; bz = 0;
    for (int i = 0; i < 30; i++) begin
      applyStimulus("t4", (i == 0), 1'b0, 1'b0, 1'b0);
      if (workout_state == 3'd2) restSeen = 1;
      if (int'(current_exercise_num) > maxex) maxex = int'(current_exercise_num);
      if (buzzer) bz++;
    end
    checkValue("t4_rest_seen", restSeen, 0);
    checkValue("t4_max_exercise", maxex, 3);
    checkValue("t4_buzz_cycles", bz, 8);
    checkValue("t4_final_state", int'(workout_state), 4);

    // Pause mid-second and resume
    $display("[TB] pause and resume");
    applyStimulus("t5_rst", 1'b0, 1'b0, 1'b0, 1'b1);
    num_ex = 9'd2; work_sec = 8'd3; rest_sec = 8'd2;
    applyStimulus("t5_start", 1'b1, 1'b0, 1'b0, 1'b0);
    runIdle("t5_run", 6);
    checkValue("t5_cd_before_pause", int'(countdown_seconds), 2);
    applyStimulus("t5_pause", 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus("t5_hold", 1'b0, 1'b0, 1'b0, 1'b0);
      if (i == 0 || i == 19) begin
        checkValue("t5_hold_state", int'(workout_state), 3);
        checkValue("t5_hold_cd", int'(countdown_seconds), 2);
      end
    end
    applyStimulus("t5_resume", 1'b0, 1'b0, 1'b1, 1'b0);
    checkValue("t5_resume_state", int'(workout_state), 1);
    checkValue("t5_resume_buzzer", int'(buzzer), 0);
    applyStimulus("t5_after1", 1'b0, 1'b0, 1'b0, 1'b0);
    checkValue("t5_after1_cd", int'(countdown_seconds), 2);
    applyStimulus("t5_after2", 1'b0, 1'b0, 1'b0, 1'b0);
    checkValue("t5_after2_cd", int'(countdown_seconds), 1);

    // Skip interactions and priorities
    $display("[TB] skip priority");
    applyStimulus("t6_rst", 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus("t6_start", 1'b1, 1'b0, 1'b0, 1'b0);
    runIdle("t6_run", 3);
    applyStimulus("t6_skip_tick", 1'b0, 1'b1, 1'b0, 1'b0);
    checkValue("t6_skip_tick_state", int'(workout_state), 2);
    checkValue("t6_skip_tick_cd", int'(countdown_seconds), 2);
    applyStimulus("t6_skip_rest", 1'b0, 1'b1, 1'b0, 1'b0);
    checkValue("t6_skip_rest_state", int'(workout_state), 1);
    checkValue("t6_skip_rest_ex", int'(current_exercise_num), 2);
    applyStimulus("t6_pause", 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus("t6_skip_paused", 1'b0, 1'b1, 1'b0, 1'b0);
    checkValue("t6_skip_paused_state", int'(workout_state), 3);
    checkValue("t6_skip_paused_cd", int'(countdown_seconds), 3);
    applyStimulus("t6_start_paused", 1'b1, 1'b0, 1'b0, 1'b0);
    checkValue("t6_start_paused_state", int'(workout_state), 3);
    applyStimulus("t6_resume", 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus("t6_pause_skip", 1'b0, 1'b1, 1'b1, 1'b0);
    checkValue("t6_pause_skip_state", int'(workout_state), 3);
    checkValue("t6_pause_skip_ex", int'(current_exercise_num), 2);
    applyStimulus("t6_resume2", 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus("t6_skip_last", 1'b0, 1'b1, 1'b0, 1'b0);
    checkValue("t6_done_state", int'(workout_state), 4);
    checkValue("t6_done_flag", int'(done), 1);
    applyStimulus("t6_skip_done", 1'b0, 1'b1, 1'b1, 1'b0);
    runIdle("t6_tail", 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
